// File: rtl/pipeline_pkg.sv
// ============================================================================
// pipeline_pkg
// Shared pipeline widths, the zero-register index and the WB control-field
// bit positions used by MEM/WB and the writeback stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipeline_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 5;
  localparam int REG_ZERO    = 0;

  // Bit positions inside the 2-bit WB control field carried by MEM/WB.
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

endpackage : pipeline_pkg

`default_nettype wire

// File: rtl/regfile_bank.sv
// ============================================================================
// regfile_bank
// Raw register storage: asynchronous clear, one synchronous write port and
// two unqualified combinational read ports.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_bank #(
  parameter int DATA_WIDTH = pipeline_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = pipeline_pkg::ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata1 = regs_q[raddr1];
  assign rdata2 = regs_q[raddr2];

endmodule : regfile_bank

`default_nettype wire

// File: rtl/wb_register_file.sv
// ============================================================================
// wb_register_file
// Writeback stage: selects the writeback value, commits it to the register
// bank and serves two decode read ports with same-cycle write bypass.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_register_file #(
  parameter int DATA_WIDTH = pipeline_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = pipeline_pkg::ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  regWrite,
  input  logic                  memToReg,
  input  logic [ADDR_WIDTH-1:0] RD,
  input  logic [DATA_WIDTH-1:0] memoryWord,
  input  logic [DATA_WIDTH-1:0] aluResult,
  input  logic [ADDR_WIDTH-1:0] readRegister1,
  input  logic [ADDR_WIDTH-1:0] readRegister2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  output logic [DATA_WIDTH-1:0] writeData
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(pipeline_pkg::REG_ZERO);

  logic                  wen;
  logic [DATA_WIDTH-1:0] bank_rdata1;
  logic [DATA_WIDTH-1:0] bank_rdata2;

  assign writeData = memToReg ? memoryWord : aluResult;

  // Gating with reset also disables the bypass while the bank is cleared.
  assign wen = regWrite && (RD != ZERO_IDX) && !reset;

  regfile_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank (
    .clock  (clock),
    .reset  (reset),
    .we     (wen),
    .waddr  (RD),
    .wdata  (writeData),
    .raddr1 (readRegister1),
    .raddr2 (readRegister2),
    .rdata1 (bank_rdata1),
    .rdata2 (bank_rdata2)
  );

  always_comb begin
    readData1 = bank_rdata1;
    if (readRegister1 == ZERO_IDX) begin
      readData1 = '0;
    end else if (wen && (RD == readRegister1)) begin
      readData1 = writeData;
    end
  end

  always_comb begin
    readData2 = bank_rdata2;
    if (readRegister2 == ZERO_IDX) begin
      readData2 = '0;
    end else if (wen && (RD == readRegister2)) begin
      readData2 = writeData;
    end
  end

endmodule : wb_register_file

`default_nettype wire

// File: tb/tb_wb_register_file.sv
// ============================================================================
// tb_wb_register_file
// Directed vector table plus hand-written reset sequences for wb_register_file.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_wb_register_file;

  logic        clock;
  logic        reset;
  logic        regWrite;
  logic        memToReg;
  logic [4:0]  RD;
  logic [31:0] memoryWord;
  logic [31:0] aluResult;
  logic [4:0]  readRegister1;
  logic [4:0]  readRegister2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] writeData;

  int passed;
  int total;

  wb_register_file dut (
    .clock         (clock),
    .reset         (reset),
    .regWrite      (regWrite),
    .memToReg      (memToReg),
    .RD            (RD),
    .memoryWord    (memoryWord),
    .aluResult     (aluResult),
    .readRegister1 (readRegister1),
    .readRegister2 (readRegister2),
    .readData1     (readData1),
    .readData2     (readData2),
    .writeData     (writeData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [4:0]  rd;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic m2r, input logic [4:0] rd,
                       input logic [31:0] mem, input logic [31:0] alu,
                       input logic [4:0] rr1, input logic [4:0] rr2);
    regWrite      = rw;
    memToReg      = m2r;
    RD            = rd;
    memoryWord    = mem;
    aluResult     = alu;
    readRegister1 = rr1;
    readRegister2 = rr2;
  endtask

  initial begin
    passed = 0;
    total  = 0;

    // Each row is checked before its rising edge; the edge then commits it.
    vecs[0] = '{1'b1, 1'b0, 5'd5,  32'h12345678, 32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 1'b0, 5'd5,  32'h00000000, 32'h00000000, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000};
    vecs[2] = '{1'b1, 1'b1, 5'd31, 32'hCAFEF00D, 32'h0BADF00D, 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[3] = '{1'b0, 1'b1, 5'd31, 32'h00000000, 32'h0BADF00D, 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D, 32'h00000000};
    vecs[4] = '{1'b1, 1'b0, 5'd0,  32'h00000000, 32'hFFFFFFFF, 5'd0,  5'd0,  32'h00000000, 32'h00000000, 32'hFFFFFFFF};
    vecs[5] = '{1'b0, 1'b0, 5'd0,  32'h00000000, 32'hFFFFFFFF, 5'd0,  5'd0,  32'h00000000, 32'h00000000, 32'hFFFFFFFF};
    vecs[6] = '{1'b1, 1'b0, 5'd7,  32'h00000000, 32'h11111111, 5'd7,  5'd5,  32'h11111111, 32'hDEADBEEF, 32'h11111111};
    vecs[7] = '{1'b0, 1'b0, 5'd7,  32'h00000000, 32'h22222222, 5'd7,  5'd7,  32'h11111111, 32'h11111111, 32'h22222222};
    vecs[8] = '{1'b1, 1'b1, 5'd5,  32'h55555555, 32'h00000000, 5'd5,  5'd7,  32'h55555555, 32'h11111111, 32'h55555555};
    vecs[9] = '{1'b0, 1'b0, 5'd5,  32'h00000000, 32'h00000000, 5'd5,  5'd31, 32'h55555555, 32'hCAFEF00D, 32'h00000000};

    reset = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      readRegister1 = 5'(i);
      readRegister2 = 5'(31 - i);
      #1;
      check($sformatf("reset_rd1[%0d]", i), readData1, 32'h0);
      check($sformatf("reset_rd2[%0d]", 31 - i), readData2, 32'h0);
    end

    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      drive(vecs[i].rw, vecs[i].m2r, vecs[i].rd, vecs[i].mem, vecs[i].alu, vecs[i].rr1, vecs[i].rr2);
      #1;
      check($sformatf("vec%0d_rd1", i), readData1, vecs[i].exp_rd1);
      check($sformatf("vec%0d_rd2", i), readData2, vecs[i].exp_rd2);
      check($sformatf("vec%0d_wd", i),  writeData, vecs[i].exp_wd);
    end

    // Asynchronous reset between edges clears r3 at once.
    @(negedge clock);
    drive(1'b1, 1'b0, 5'd3, 32'h0, 32'hA5A5A5A5, 5'd3, 5'd3);
    @(negedge clock);
    drive(1'b0, 1'b0, 5'd3, 32'h0, 32'h0, 5'd3, 5'd5);
    #1;
    check("r3_stored", readData1, 32'hA5A5A5A5);
    #1;
    reset = 1'b1;
    #1;
    check("r3_async_clear", readData1, 32'h0);
    check("r5_async_clear", readData2, 32'h0);

    // Write held under reset: no bypass, no commit; writeData still follows the mux.
    drive(1'b1, 1'b0, 5'd3, 32'h0, 32'hA5A5A5A5, 5'd3, 5'd3);
    #1;
    check("reset_no_bypass", readData1, 32'h0);
    check("reset_wd_mux", writeData, 32'hA5A5A5A5);
    @(posedge clock);
    #1;
    check("reset_no_write", readData1, 32'h0);

    // Mid-cycle deassert: bypass reappears, but storage stays clear until an edge.
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("deassert_bypass", readData2, 32'hA5A5A5A5);
    regWrite = 1'b0;
    #1;
    check("deassert_no_write", readData1, 32'h0);
    @(posedge clock);
    #1;
    check("after_edge_no_write", readData1, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule : tb_wb_register_file

`default_nettype wire

// File: doc/wb_register_file.md
# wb_register_file

Writeback end of the MEM/WB interface: consumes the pipeline register's `memoryWord`, `aluResult`, `RD`, `regWrite` and `memToReg` outputs, selects the writeback value and commits it to a 32-entry general-purpose register file. It also serves the decode stage's two read ports. Register 0 is hardwired to zero. A same-cycle write is bypassed to both read ports, so an instruction in decode sees the value being written back in that cycle.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register and data width
- `ADDR_WIDTH`, 5, register index width; the file holds 2^ADDR_WIDTH registers

Ports:
- `clock`  in  1  single clock; all writes on rising edge
- `reset`  in  1  asynchronous, active-high; clears every register
- `regWrite`  in  1  writeback enable from MEM/WB
- `memToReg`  in  1  1 selects `memoryWord`, 0 selects `aluResult`
- `RD`  in  ADDR_WIDTH  destination register index from MEM/WB
- `memoryWord`  in  DATA_WIDTH  load data from MEM/WB
- `aluResult`  in  DATA_WIDTH  ALU result from MEM/WB
- `readRegister1`  in  ADDR_WIDTH  decode read index A
- `readRegister2`  in  ADDR_WIDTH  decode read index B
- `readData1`  out  DATA_WIDTH  value of register A, with bypass applied
- `readData2`  out  DATA_WIDTH  value of register B, with bypass applied
- `writeData`  out  DATA_WIDTH  selected writeback value, exported for the forwarding unit

## Operation
- Writeback mux is combinational: `writeData = memToReg ? memoryWord : aluResult`.
- Write qualifier: `wen = regWrite && (RD != 0) && !reset`.
- On a rising edge of `clock` with `wen` = 1, `regs[RD]` takes `writeData`. Any other edge leaves all registers unchanged.
- `regs[0]` is never written and always reads 0, even when `regWrite` = 1 and `RD` = 0.
- Read ports are combinational and handled independently. For port n:
  - If `readRegister_n` is 0, the output is 0.
  - Else if `wen` and `RD == readRegister_n`, the output is `writeData` (bypass).
  - Otherwise the output is `regs[readRegister_n]`.
- Both ports may address the same register; both return the same value, with the bypass applied to each.
- There is no state machine. The only sequential state is the register array.

## Timing
- Write latency: 1 cycle. The value presented before edge k is readable from storage after edge k. Through the bypass it is visible combinationally in the same cycle it is presented.
- Read latency: 0 cycles, purely combinational from index to data.
- Reset: while `reset` = 1, all registers are 0 immediately, independent of `clock`.
  - `readData1`/`readData2` = 0 during reset; the bypass is disabled because `wen` is gated by `reset`.
  - `writeData` still reflects the mux.
- Reset deasserted mid-cycle: no write occurs before the next rising edge of `clock`.
- Reset asserted on the same edge as a write: reset wins and the register remains 0.
- Power-up without reset: contents undefined; the bench must always apply reset first.

## Structure
- The shared package `pipeline_pkg` holds:
  - `DATA_WIDTH`, `ADDR_WIDTH` and `REG_ZERO` (= 0)
  - the `WB` control-field bit positions (`WB_REGWRITE` = 1, `WB_MEMTOREG` = 0), so that MEM/WB and this block decode the field identically
- Sub-module `regfile_bank`:
  - contents: the storage array, the asynchronous clear and the synchronous write port
  - interface: `clock`, `reset`, `we`, `waddr`, `wdata`, two raw read ports
- The top level holds the writeback mux, the `wen` qualifier, the zero-register masking and the bypass logic.

## Test plan
- Reset, then read all 32 indices on both ports -> every read is 0x00000000.
- `regWrite`=1, `memToReg`=0, `RD`=5, `aluResult`=0xDEADBEEF, `memoryWord`=0x12345678; read index 5 before the edge -> `readData1`=0xDEADBEEF via bypass; after the edge with `regWrite`=0 -> 0xDEADBEEF from storage.
- `memToReg`=1, `RD`=31, `memoryWord`=0xCAFEF00D, both ports reading 31 -> both equal 0xCAFEF00D in the same cycle and after the edge; `writeData`=0xCAFEF00D.
- `regWrite`=1, `RD`=0, `aluResult`=0xFFFFFFFF, both ports reading 0 -> both 0 before and after the edge; no bypass.
- Write 0x11111111 to r7, then `regWrite`=0 with `RD`=7 and `aluResult`=0x22222222 -> r7 still reads 0x11111111 and no bypass occurs.
- Write 0xA5A5A5A5 to r3, assert `reset` asynchronously between edges -> r3 reads 0 immediately. Then hold `reset`=1 across a write to r3 -> r3 remains 0 after the edge.
